spi_reg_bank_slave: RTL and testbench
=====================================

Name: spi_reg_bank_slave

Overview:
Parametrised successor to the current user-SPI register slave. It oversamples SPI mode 0 on the system register clock and supports burst transfers with address auto-increment. Configurable register width, count and address width; read-address offset; out-of-range handling; clear-on-read strobe; and framing-error reporting. It sits between the board user-SPI pins (after CS demux) and the register map (firmware date/time/type, test array).

Parameters:
DWIDTH, 16, register data width in bits (1..32)
ADDR_W, 7, address field width in header
REG_COUNT, 16, number of readable registers in p_in_reg_rd_data
RD_OFFSET, 64, header address that maps to read index 0
AUTO_INC, 1, 1 = address +1 per data word in a burst; 0 = fixed address
SYNC_STAGES, 2, synchroniser depth on SCK/CS/MOSI (>=2)

Ports:
p_in_clk  in  1  register/system clock; must be >= 8x SCK
p_in_rst_n  in  1  synchronous active-low reset
p_in_spi_cs_n  in  1  chip select, active low, asynchronous
p_in_spi_clk  in  1  SCK, asynchronous
p_in_spi_mosi  in  1  MOSI, asynchronous
p_out_spi_miso  out  1  MISO; 1 while CS high
p_in_reg_rd_data  in  REG_COUNT*DWIDTH  flat read bus, index i at [i*DWIDTH +: DWIDTH]
p_out_reg_wr_addr  out  ADDR_W  write address
p_out_reg_wr_data  out  DWIDTH  write data
p_out_reg_wr_en  out  1  one-cycle write strobe
p_out_reg_rd_addr  out  ADDR_W  address of word just loaded for read
p_out_reg_rd_stb  out  1  one-cycle strobe per read word (for clear-on-read registers)
p_out_frame_err  out  1  one-cycle pulse on malformed frame

Behaviour:
- Reset (p_in_rst_n=0 at a p_in_clk edge): FSM=IDLE. miso=1, wr_en=0, rd_stb=0, frame_err=0, wr_addr=0, wr_data=0, rd_addr=0. Bit counters and shifters are cleared. A reset mid-frame abandons the frame without a write. After reset release, the FSM waits for a CS rising edge before it accepts a new frame.
- Inputs pass through SYNC_STAGES flops. SCK rise/fall are detected from the last two synced samples. All logic runs on p_in_clk.
- Frame format, MSB first, SPI mode 0:
  - Header: 1+ADDR_W bits = {rw (1=read), addr}.
  - Then N>=0 data words of DWIDTH bits each.
- FSM states:
  - IDLE -> HDR on synced CS falling.
  - HDR: shift MOSI on each synced SCK rise. After 1+ADDR_W bits, latch rw/addr -> DATA.
  - DATA: count DWIDTH bits per word. Stays in DATA for subsequent words.
  - Any state -> IDLE on synced CS rising.
- Write word:
  - In the cycle after the synced rise carrying a word's last bit, wr_en=1 for exactly 1 cycle with wr_addr=current addr and wr_data=shifted word.
  - Latency from the pin SCK edge is SYNC_STAGES+2 clocks.
  - Writes go to any address; the register map decodes them.
- Read word:
  - Index = addr-RD_OFFSET.
  - Index in range: the word is loaded from p_in_reg_rd_data in the cycle the header (or the previous word) completes, and rd_stb=1 for that cycle with rd_addr=addr.
  - Index out of range (addr<RD_OFFSET or index>=REG_COUNT): word=0, no rd_stb.
  - MISO presents the MSB before the next SCK rise and shifts on each synced SCK fall. In a read frame, MOSI data bits are ignored.
- Addressing:
  - AUTO_INC=1: addr increments after each completed word and wraps modulo 2^ADDR_W.
  - AUTO_INC=0: addr is held.
- frame_err pulses 1 cycle on CS rise when the header is incomplete or a partial data word is pending (bit count != 0). A partial word is never written.
- CS high: miso=1, so the upstream AND-combine with other slaves is transparent.
- If CS rises in the same cycle as the last bit's SCK rise, the word completes, the write is issued, and no error is reported. The SCK edge is processed before CS.

Decomposition:
- Package spi_reg_pkg:
  - Header width function (1+ADDR_W).
  - State encoding (IDLE/HDR/DATA).
  - RW bit constants (READ=1, WRITE=0).
- One sub-module, spi_sync_edge: parametrised SYNC_STAGES synchroniser for SCK/CS/MOSI plus sck_rise/sck_fall/cs_fall/cs_rise one-cycle pulses.

Test Plan:
- Write of 0xA5C3 to addr 0x10, DWIDTH=16 -> exactly one wr_en with wr_addr=0x10, wr_data=0xA5C3, SYNC_STAGES+2 clocks after the last SCK rise. No frame_err.
- Read burst of 3 words from addr 64 with rd_data[0..2]=0x1111,0x2222,0x3333 -> MISO bits give 0x1111,0x2222,0x3333. rd_stb pulses 3 times with rd_addr=64,65,66.
- Read of addr 63 and addr 80 (REG_COUNT=16) -> MISO returns 0x0000 for both; no rd_stb.
- Write burst of 2 words to addr 0x7F with AUTO_INC=1 -> writes to 0x7F then 0x00 (wrap). The same burst with AUTO_INC=0 -> both writes to 0x7F.
- CS raised after 9 bits of a data word -> no wr_en for that word, frame_err=1 for one cycle. A CS rise during the header also gives frame_err.
- p_in_rst_n=0 mid-burst -> all outputs at reset values next clock, miso=1. A new frame after CS toggle completes normally.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register-bank slave.
// Header layout is {rw, addr}, MSB first.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int hdr_width(input int addr_w);
        return 1 + addr_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises SCK/CS/MOSI into the system clock domain and
// produces registered single-cycle edge pulses plus aligned MOSI.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sck,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sck_sh;
    logic [SYNC_STAGES-1:0] r_cs_sh;
    logic [SYNC_STAGES-1:0] r_mosi_sh;
    logic                   r_sck_d;
    logic                   r_cs_d;
    logic                   r_sck_rise;
    logic                   r_sck_fall;
    logic                   r_cs_fall;
    logic                   r_cs_rise;
    logic                   r_mosi;
    logic                   w_sck;
    logic                   w_cs;

    assign w_sck = r_sck_sh[SYNC_STAGES-1];
    assign w_cs  = r_cs_sh[SYNC_STAGES-1];

    // CS resets to the deasserted level so reset never looks like a frame start
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sck_sh   <= '0;
            r_cs_sh    <= '1;
            r_mosi_sh  <= '0;
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b1;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_cs_rise  <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_sck_sh   <= {r_sck_sh[SYNC_STAGES-2:0], i_sck};
            r_cs_sh    <= {r_cs_sh[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sh  <= {r_mosi_sh[SYNC_STAGES-2:0], i_mosi};
            r_sck_d    <= w_sck;
            r_cs_d     <= w_cs;
            r_sck_rise <= w_sck & ~r_sck_d;
            r_sck_fall <= ~w_sck & r_sck_d;
            r_cs_fall  <= ~w_cs & r_cs_d;
            r_cs_rise  <= w_cs & ~r_cs_d;
            r_mosi     <= r_mosi_sh[SYNC_STAGES-1];
        end
    end

    assign o_sck_rise = r_sck_rise;
    assign o_sck_fall = r_sck_fall;
    assign o_cs_fall  = r_cs_fall;
    assign o_cs_rise  = r_cs_rise;
    assign o_mosi     = r_mosi;

endmodule

// File: rtl/spi_reg_bank_slave.sv
// Oversampled SPI mode-0 register slave with burst transfers,
// address auto-increment, clear-on-read strobe and framing errors.
module spi_reg_bank_slave
    import spi_reg_pkg::*;
#(
    parameter int DWIDTH      = 16,
    parameter int ADDR_W      = 7,
    parameter int REG_COUNT   = 16,
    parameter int RD_OFFSET   = 64,
    parameter int AUTO_INC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          p_in_clk,
    input  logic                          p_in_rst_n,
    input  logic                          p_in_spi_cs_n,
    input  logic                          p_in_spi_clk,
    input  logic                          p_in_spi_mosi,
    output logic                          p_out_spi_miso,
    input  logic [REG_COUNT*DWIDTH-1:0]   p_in_reg_rd_data,
    output logic [ADDR_W-1:0]             p_out_reg_wr_addr,
    output logic [DWIDTH-1:0]             p_out_reg_wr_data,
    output logic                          p_out_reg_wr_en,
    output logic [ADDR_W-1:0]             p_out_reg_rd_addr,
    output logic                          p_out_reg_rd_stb,
    output logic                          p_out_frame_err
);

    localparam int HDR_W = hdr_width(ADDR_W);
    localparam int MAX_W = (HDR_W > DWIDTH) ? HDR_W : DWIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_mosi;

    state_t            r_state;
    logic              r_armed;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [HDR_W-1:0]  r_hdr;
    logic [DWIDTH-1:0] r_rx;
    logic [DWIDTH-1:0] r_tx;
    logic [CNT_W-1:0]  r_bcnt;
    logic              r_miso;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DWIDTH-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_stb;
    logic              r_frame_err;

    logic [HDR_W-1:0]  w_hdr_nxt;
    logic [ADDR_W-1:0] w_hdr_addr;
    logic              w_hdr_rw;
    logic [DWIDTH-1:0] w_rx_nxt;
    logic [DWIDTH-1:0] w_tx_shl;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [DWIDTH-1:0] w_ld_word;
    logic              w_ld_hit;
    logic              w_hdr_done;
    logic              w_word_done;
    logic              w_pend;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk      (p_in_clk),
        .i_rst_n    (p_in_rst_n),
        .i_sck      (p_in_spi_clk),
        .i_cs_n     (p_in_spi_cs_n),
        .i_mosi     (p_in_spi_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise),
        .o_mosi     (w_mosi)
    );

    assign w_hdr_nxt  = (r_hdr << 1) | HDR_W'(w_mosi);
    assign w_hdr_addr = w_hdr_nxt[ADDR_W-1:0];
    assign w_hdr_rw   = w_hdr_nxt[HDR_W-1];
    assign w_rx_nxt   = (r_rx << 1) | DWIDTH'(w_mosi);
    assign w_tx_shl   = r_tx << 1;
    assign w_addr_nxt = (AUTO_INC != 0) ? r_addr + ADDR_W'(1) : r_addr;

    assign w_hdr_done  = (r_state == ST_HDR) && w_sck_rise &&
                         (r_bcnt == CNT_W'(HDR_W - 1));
    assign w_word_done = (r_state == ST_DATA) && w_sck_rise &&
                         (r_bcnt == CNT_W'(DWIDTH - 1));

    // First read word comes from the header address, later ones from the next address
    assign w_ld_addr = (r_state == ST_HDR) ? w_hdr_addr : w_addr_nxt;

    always_comb begin
        w_ld_hit  = 1'b0;
        w_ld_word = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (32'(w_ld_addr) == 32'(RD_OFFSET + i)) begin
                w_ld_hit  = 1'b1;
                w_ld_word = p_in_reg_rd_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // A coincident last-bit SCK rise completes the frame before CS closes it
    always_comb begin
        w_pend = 1'b0;
        if (r_state == ST_HDR) begin
            w_pend = !w_hdr_done;
        end else if (r_state == ST_DATA) begin
            w_pend = w_sck_rise ? !w_word_done : (r_bcnt != '0);
        end
    end

    always_ff @(posedge p_in_clk) begin
        if (!p_in_rst_n) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_rw        <= RW_WRITE;
            r_addr      <= '0;
            r_hdr       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_bcnt      <= '0;
            r_miso      <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_addr   <= '0;
            r_rd_stb    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rd_stb    <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b1;
                    r_bcnt <= '0;
                    if (w_cs_fall && r_armed) begin
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_sck_rise) begin
                        r_hdr  <= w_hdr_nxt;
                        r_bcnt <= r_bcnt + 1'b1;
                        if (w_hdr_done) begin
                            r_bcnt  <= '0;
                            r_rw    <= w_hdr_rw;
                            r_addr  <= w_hdr_addr;
                            r_state <= ST_DATA;
                            if (w_hdr_rw == RW_READ) begin
                                r_tx      <= w_ld_word;
                                r_miso    <= w_ld_word[DWIDTH-1];
                                r_rd_stb  <= w_ld_hit;
                                r_rd_addr <= w_ld_addr;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sck_rise) begin
                        r_rx   <= w_rx_nxt;
                        r_bcnt <= r_bcnt + 1'b1;
                        if (w_word_done) begin
                            r_bcnt <= '0;
                            r_addr <= w_addr_nxt;
                            if (r_rw == RW_WRITE) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_addr;
                                r_wr_data <= w_rx_nxt;
                            end else begin
                                r_tx      <= w_ld_word;
                                r_miso    <= w_ld_word[DWIDTH-1];
                                r_rd_stb  <= w_ld_hit;
                                r_rd_addr <= w_ld_addr;
                            end
                        end
                    end else if (w_sck_fall && (r_rw == RW_READ) &&
                                 (r_bcnt != '0)) begin
                        // The fall right after a load keeps the MSB on the line
                        r_tx   <= w_tx_shl;
                        r_miso <= w_tx_shl[DWIDTH-1];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_cs_rise) begin
                r_armed     <= 1'b1;
                r_state     <= ST_IDLE;
                r_miso      <= 1'b1;
                r_frame_err <= w_pend;
            end
        end
    end

    assign p_out_spi_miso    = r_miso;
    assign p_out_reg_wr_addr = r_wr_addr;
    assign p_out_reg_wr_data = r_wr_data;
    assign p_out_reg_wr_en   = r_wr_en;
    assign p_out_reg_rd_addr = r_rd_addr;
    assign p_out_reg_rd_stb  = r_rd_stb;
    assign p_out_frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bank_slave.sv
// Directed bench for spi_reg_bank_slave: writes, read bursts,
// range limits, address wrap, framing errors and mid-frame reset.
module tb_spi_reg_bank_slave;

    localparam int DW   = 16;
    localparam int AW   = 7;
    localparam int RC   = 16;
    localparam int SYNC = 2;
    localparam int HALF = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cs_n;
    logic           sck;
    logic           mosi;
    logic [RC*DW-1:0] rd_bus;

    logic           miso;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           wr_en;
    logic [AW-1:0]  rd_addr;
    logic           rd_stb;
    logic           ferr;

    logic           f_miso;
    logic [AW-1:0]  f_wr_addr;
    logic [DW-1:0]  f_wr_data;
    logic           f_wr_en;
    logic [AW-1:0]  f_rd_addr;
    logic           f_rd_stb;
    logic           f_ferr;

    logic [AW+DW-1:0] q_wr[$];
    logic [AW+DW-1:0] q_wr_fix[$];
    logic [AW-1:0]    q_rd[$];
    int               n_stb;
    int               n_ferr;
    int               n_vec;
    int               n_bad;

    always #5 clk = ~clk;

    spi_reg_bank_slave #(
        .DWIDTH(DW), .ADDR_W(AW), .REG_COUNT(RC), .RD_OFFSET(64),
        .AUTO_INC(1), .SYNC_STAGES(SYNC)
    ) u_dut (
        .p_in_clk          (clk),
        .p_in_rst_n        (rst_n),
        .p_in_spi_cs_n     (cs_n),
        .p_in_spi_clk      (sck),
        .p_in_spi_mosi     (mosi),
        .p_out_spi_miso    (miso),
        .p_in_reg_rd_data  (rd_bus),
        .p_out_reg_wr_addr (wr_addr),
        .p_out_reg_wr_data (wr_data),
        .p_out_reg_wr_en   (wr_en),
        .p_out_reg_rd_addr (rd_addr),
        .p_out_reg_rd_stb  (rd_stb),
        .p_out_frame_err   (ferr)
    );

    spi_reg_bank_slave #(
        .DWIDTH(DW), .ADDR_W(AW), .REG_COUNT(RC), .RD_OFFSET(64),
        .AUTO_INC(0), .SYNC_STAGES(SYNC)
    ) u_dut_fix (
        .p_in_clk          (clk),
        .p_in_rst_n        (rst_n),
        .p_in_spi_cs_n     (cs_n),
        .p_in_spi_clk      (sck),
        .p_in_spi_mosi     (mosi),
        .p_out_spi_miso    (f_miso),
        .p_in_reg_rd_data  (rd_bus),
        .p_out_reg_wr_addr (f_wr_addr),
        .p_out_reg_wr_data (f_wr_data),
        .p_out_reg_wr_en   (f_wr_en),
        .p_out_reg_rd_addr (f_rd_addr),
        .p_out_reg_rd_stb  (f_rd_stb),
        .p_out_frame_err   (f_ferr)
    );

    always begin
        @(posedge clk);
        #1;
        if (wr_en) q_wr.push_back({wr_addr, wr_data});
        if (f_wr_en) q_wr_fix.push_back({f_wr_addr, f_wr_data});
        if (rd_stb) begin
            q_rd.push_back(rd_addr);
            n_stb++;
        end
        if (ferr) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (4*HALF) @(negedge clk);
    endtask

    // Master drives MOSI while SCK low and samples MISO just before each rise
    task automatic shift(input logic [31:0] v, input int n,
                         output logic [31:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            repeat (HALF) @(negedge clk);
            got = {got[30:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] g0, g1, g2, ga, gb;
        int          lat, stb0, fe0;
        n_vec  = 0;
        n_bad  = 0;
        n_stb  = 0;
        n_ferr = 0;
        rst_n  = 1'b0;
        cs_n   = 1'b1;
        sck    = 1'b0;
        mosi   = 1'b0;
        for (int i = 0; i < RC; i++) rd_bus[i*DW +: DW] = DW'(16'hE000 + i);
        rd_bus[0*DW +: DW] = 16'h1111;
        rd_bus[1*DW +: DW] = 16'h2222;
        rd_bus[2*DW +: DW] = 16'h3333;
        repeat (4) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_rd_stb", 32'(rd_stb), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        rst_n = 1'b1;
        cs_lo();
        cs_hi();

        // single write 0xA5C3 to 0x10 with latency from last SCK rise
        q_wr.delete();
        fe0 = n_ferr;
        cs_lo();
        shift(32'h10, 8, g0);
        shift(32'hA5C3 >> 1, 15, g0);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        lat = 0;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (wr_en && lat == 0) lat = k;
        end
        sck = 1'b0;
        cs_hi();
        chk("wr_count", 32'(q_wr.size()), 32'd1);
        chk("wr_word", 32'(q_wr[0]), 32'({7'h10, 16'hA5C3}));
        chk("wr_latency", 32'(lat), 32'(SYNC + 2));
        chk("wr_ferr", 32'(n_ferr - fe0), 32'd0);

        // read burst of three words from 64
        q_rd.delete();
        stb0 = n_stb;
        fe0  = n_ferr;
        cs_lo();
        shift(32'hC0, 8, g0);
        shift(32'h0, 16, g0);
        shift(32'h0, 16, g1);
        shift(32'h0, 15, ga);
        chk("rd_stb_count", 32'(n_stb - stb0), 32'd3);
        shift(32'h0, 1, gb);
        g2 = {ga[30:0], gb[0]};
        cs_hi();
        chk("rd_w0", g0, 32'h1111);
        chk("rd_w1", g1, 32'h2222);
        chk("rd_w2", g2, 32'h3333);
        chk("rd_addr0", 32'(q_rd[0]), 32'd64);
        chk("rd_addr1", 32'(q_rd[1]), 32'd65);
        chk("rd_addr2", 32'(q_rd[2]), 32'd66);
        chk("rd_ferr", 32'(n_ferr - fe0), 32'd0);

        // out-of-range reads below and above the window
        stb0 = n_stb;
        cs_lo();
        shift(32'hBF, 8, g0);
        shift(32'h0, 15, ga);
        chk("oor63_stb", 32'(n_stb - stb0), 32'd0);
        shift(32'h0, 1, gb);
        cs_hi();
        chk("oor63_data", {ga[30:0], gb[0]}, 32'h0);
        stb0 = n_stb;
        cs_lo();
        shift(32'hD0, 8, g0);
        shift(32'h0, 16, g1);
        cs_hi();
        chk("oor80_stb", 32'(n_stb - stb0), 32'd0);
        chk("oor80_data", g1, 32'h0);

        // two-word write burst at 0x7F: wrap vs fixed address
        q_wr.delete();
        q_wr_fix.delete();
        cs_lo();
        shift(32'h7F, 8, g0);
        shift(32'h1234, 16, g0);
        shift(32'hBEEF, 16, g0);
        cs_hi();
        chk("inc_count", 32'(q_wr.size()), 32'd2);
        chk("inc_w0", 32'(q_wr[0]), 32'({7'h7F, 16'h1234}));
        chk("inc_w1", 32'(q_wr[1]), 32'({7'h00, 16'hBEEF}));
        chk("fix_count", 32'(q_wr_fix.size()), 32'd2);
        chk("fix_w0", 32'(q_wr_fix[0]), 32'({7'h7F, 16'h1234}));
        chk("fix_w1", 32'(q_wr_fix[1]), 32'({7'h7F, 16'hBEEF}));

        // CS raised after 9 data bits, then during the header
        q_wr.delete();
        fe0 = n_ferr;
        cs_lo();
        shift(32'h05, 8, g0);
        shift(32'h1FF, 9, g0);
        cs_hi();
        chk("part_wr", 32'(q_wr.size()), 32'd0);
        chk("part_ferr", 32'(n_ferr - fe0), 32'd1);
        fe0 = n_ferr;
        cs_lo();
        shift(32'h5, 3, g0);
        cs_hi();
        chk("hdr_ferr", 32'(n_ferr - fe0), 32'd1);

        // CS rises together with the last SCK rise
        q_wr.delete();
        fe0 = n_ferr;
        cs_lo();
        shift(32'h22, 8, g0);
        shift(32'h0F0F >> 1, 15, g0);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sck  = 1'b1;
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
        repeat (4*HALF) @(negedge clk);
        chk("sim_count", 32'(q_wr.size()), 32'd1);
        chk("sim_word", 32'(q_wr[0]), 32'({7'h22, 16'h0F0F}));
        chk("sim_ferr", 32'(n_ferr - fe0), 32'd0);

        // reset in the middle of a read burst
        q_wr.delete();
        cs_lo();
        shift(32'hC0, 8, g0);
        shift(32'h0, 5, g0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_miso", 32'(miso), 32'd1);
        chk("mid_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rd_stb", 32'(rd_stb), 32'd0);
        chk("mid_ferr", 32'(ferr), 32'd0);
        chk("mid_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fe0 = n_ferr;
        cs_hi();
        cs_lo();
        shift(32'h33, 8, g0);
        shift(32'h5A5A, 16, g0);
        cs_hi();
        chk("post_ferr", 32'(n_ferr - fe0), 32'd0);
        chk("post_count", 32'(q_wr.size()), 32'd1);
        chk("post_word", 32'(q_wr[0]), 32'({7'h33, 16'h5A5A}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
